// File: rtl/nibble_serial_logic_unit_pkg.sv
// Shared encodings for the nibble-serial logic unit: operations, FSM states, slice width.
package nibble_serial_logic_unit_pkg;

  localparam int SLICE_DEFAULT = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_logic_unit_slice.sv
// Combinational bitwise slice, the single shared resource stepped across all nibbles.
module logic_slice4
  import nibble_serial_logic_unit_pkg::*;
#(
  parameter int W = SLICE_DEFAULT
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOR:  o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/nibble_serial_logic_unit.sv
// Multi-cycle 32-bit logic unit: one 4-bit slice evaluated per clock over all nibbles.
// start accepted in IDLE, NSLICES RUN cycles, one DONE cycle carrying the committed result.
module nibble_serial_logic_unit
  import nibble_serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             zero
);

  // WIDTH must be a multiple of SLICE; NSLICES is derived, never overridden.
  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICES - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;

  logic [SLICE-1:0] w_slice_y;
  logic [WIDTH-1:0] w_res_next;

  logic_slice4 #(.W(SLICE)) u_slice (
    .i_a  (r_a[SLICE-1:0]),
    .i_b  (r_b[SLICE-1:0]),
    .i_op (r_op),
    .o_y  (w_slice_y)
  );

  // Result fills from the top so after NSLICES passes nibble 0 lands in bits [SLICE-1:0].
  assign w_res_next = {w_slice_y, r_res[WIDTH-1:SLICE]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= input1;
            r_b     <= input2;
            r_op    <= op;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> SLICE;
          r_b   <= r_b >> SLICE;
          r_res <= w_res_next;
          if (r_cnt == CNT_LAST) begin
            r_out   <= w_res_next;
            r_zero  <= (w_res_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done   = (r_state == ST_DONE);
  assign Output = r_out;
  assign zero   = r_zero;

endmodule

// File: tb/tb_nibble_serial_logic_unit.sv
// Directed bench for nibble_serial_logic_unit: results checked by a done-triggered scoreboard monitor.
module tb_nibble_serial_logic_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        busy;
  logic        done;
  logic [31:0] Output;
  logic        zero;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_out = 32'h0;
  logic        rst_q;

  nibble_serial_logic_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .Output (Output),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rst_q <= rst_n;

  // Monitor: pops an expectation on every done pulse, otherwise Output must hold the last commit.
  always @(negedge clk) begin
    if (rst_q === 1'b0) begin
      exp_q.delete();
      exp_out = 32'h0;
      chk("rst_out", Output, 32'h0);
      chk("rst_zero", {31'b0, zero}, 32'h1);
    end else if (rst_q === 1'b1) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL spurious_done: done=1 with no pending operation");
        end else begin
          exp_out = exp_q.pop_front();
          chk("result", Output, exp_out);
          chk("result_zero", {31'b0, zero}, {31'b0, exp_out == 32'h0});
        end
      end else begin
        chk("hold_out", Output, exp_out);
      end
    end
  end

  task automatic expect_busy_window(input int k);
    chk($sformatf("busy_c%0d", k), {31'b0, busy}, 32'h1);
    chk($sformatf("done_c%0d", k), {31'b0, done}, {31'b0, k == 9});
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    start = 1'b1; op = o; input1 = a; input2 = b;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      expect_busy_window(k);
      input1 = $urandom; input2 = $urandom; op = 2'($urandom);
      tick();
    end
    chk("idle_after", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; input1 = '0; input2 = '0;
    repeat (3) tick();
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_out", Output, 32'h0);
    chk("reset_zero", {31'b0, zero}, 32'h1);
    rst_n = 1'b1;
    tick();

    run_op(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000);
    run_op(2'b00, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h05A005A0);
    run_op(2'b01, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hAFF5AFF5);
    run_op(2'b10, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hAA55AA55);
    run_op(2'b11, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h500A500A);
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);

    // start pulses sampled at edges T+4 (RUN) and T+9 (DONE) must be ignored
    start = 1'b1; op = 2'b00; input1 = 32'h12345678; input2 = 32'hFFFFFFFF;
    exp_q.push_back(32'h12345678);
    tick();
    for (int k = 1; k <= 9; k++) begin
      expect_busy_window(k);
      start = (k == 4) || (k == 9);
      op = 2'b01; input1 = 32'hFFFFFFFF; input2 = 32'hFFFFFFFF;
      tick();
    end
    start = 1'b0;
    chk("ignored_idle", {31'b0, busy}, 32'h0);
    tick();

    // start held high: accepted at T and T+10 only
    start = 1'b1; op = 2'b10; input1 = 32'hDEADBEEF; input2 = 32'h0000FFFF;
    exp_q.push_back(32'hDEAD4110);
    tick();
    for (int k = 1; k <= 19; k++) begin
      if (k == 10) begin
        chk("held_idle", {31'b0, busy}, 32'h0);
        op = 2'b01; input1 = 32'h00F000F0; input2 = 32'h0F000F00;
        exp_q.push_back(32'h0FF00FF0);
      end else begin
        expect_busy_window(k > 10 ? k - 10 : k);
        input1 = $urandom; input2 = $urandom; op = 2'($urandom);
      end
      if (k == 19) start = 1'b0;
      tick();
    end
    chk("held_end_idle", {31'b0, busy}, 32'h0);

    // reset sampled at T+5 aborts the operation
    start = 1'b1; op = 2'b00; input1 = 32'hFFFFFFFF; input2 = 32'h13572468;
    exp_q.push_back(32'h13572468);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      expect_busy_window(k);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_out", Output, 32'h0);
    chk("abort_zero", {31'b0, zero}, 32'h1);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_done", {31'b0, done}, 32'h0);
      tick();
    end

    run_op(2'b10, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0);

    tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("done_count", done_cnt, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_logic_unit.md
Name: nibble_serial_logic_unit

Overview:
- Multi-cycle, area-reduced bitwise logic unit for the datapath.
- One shared 4-bit logic slice is time-shared over the eight nibbles of a 32-bit operand pair, one nibble per clock.
- Sequences operand capture, per-nibble evaluation and result commit.
- Presents a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, slice width in bits.
- NSLICES, WIDTH/SLICE (8), number of slice passes per operation; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- input1  input  WIDTH  operand A, sampled with an accepted start.
- input2  input  WIDTH  operand B, sampled with an accepted start.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse; the new result is valid on Output in the same cycle.
- Output  output  WIDTH  last committed result.
- zero  output  1  high when the committed Output is all zeros.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low (rst_n sampled at the rising edge of clk).
- Reset values:
  - State IDLE.
  - busy=0, done=0, Output=0, zero=1.
  - Internal operand, result and count registers are cleared to 0.
  - Reset asserted mid-operation aborts it. No done pulse is produced, and Output returns to 0.
- States (encoding in the package):
  - IDLE: busy=0. When start=1 at an edge:
    - latch input1/input2 into shift registers A_q/B_q;
    - latch op into op_q;
    - clear cnt and R_q;
    - next state RUN.
    - start=0 stays in IDLE.
  - RUN: busy=1. Each cycle:
    - the slice computes op_q on A_q[3:0], B_q[3:0];
    - A_q and B_q shift right by SLICE;
    - R_q shifts right by SLICE with the slice result inserted at R_q[WIDTH-1:WIDTH-SLICE];
    - cnt increments.
    - When cnt==NSLICES-1, the next state is DONE, and at that same edge Output and zero are loaded from the completed R_q value (including the final slice).
  - DONE: busy=1, done=1 for exactly this cycle. Next state is always IDLE.
- Latency:
  - start accepted at edge T.
  - RUN occupies cycles T+1..T+NSLICES.
  - done=1 in cycle T+NSLICES+1 (cycle 9 for default parameters).
  - Initiation interval is NSLICES+2 cycles.
- Handshake rules:
  - start while busy=1 (RUN or DONE) is ignored: not queued, operands not re-sampled.
  - start can be held high continuously. A new operation is then accepted on the first IDLE cycle after DONE.
  - input1/input2/op may change freely after acceptance without affecting the operation in flight.
- Output stability:
  - Output and zero change only at the RUN→DONE commit edge or on reset.
  - During RUN they hold the previous result; partial results are never visible.
- Arithmetic:
  - Purely bitwise; no carries and no width growth.
  - NOR is ~(a|b) per bit.
  - cnt is clog2(NSLICES) bits wide and never wraps during normal operation (terminal compare at NSLICES-1).
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package contents:
  - op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR);
  - state encodings (ST_IDLE, ST_RUN, ST_DONE);
  - SLICE default.
- One sub-module: logic_slice4, a combinational 4-bit a, b, op -> y unit. It is instantiated once and is the shared resource being scheduled.
- The FSM, counter and shift registers live in the top module.

Test Plan:
- Reset, then AND: op=00, A=0xFFFF0000, B=0x0F0F0F0F, start pulse at edge T.
  - Required: busy=1 in T+1..T+9, done=1 only in T+9.
  - Output=0x0F0F0000, zero=0 from T+9 onward.
- Each op with A=0xA5A5A5A5, B=0x0FF00FF0.
  - Required: AND 0x05A005A0, OR 0xAFF5AFF5, XOR 0xAA55AA55, NOR 0x500A500A.
  - Each has a single done pulse.
- NOR with A=0xFFFFFFFF, B=0x00000000.
  - Required: Output=0x00000000, zero=1.
  - Prior Output stays unchanged throughout RUN until the commit.
- Start during busy: accept AND(0x12345678, 0xFFFFFFFF), then pulse start with different operands at T+4 and T+9.
  - Required: both pulses are ignored, exactly one done, Output=0x12345678.
- Start held high with operand changes each cycle.
  - Required: back-to-back operations accepted at T and T+10, using operands sampled at those edges; done pulses at T+9 and T+19.
- Reset mid-operation: rst_n=0 sampled at T+5.
  - Required: from T+5, state IDLE, busy=0, Output=0, zero=1, and no done pulse follows.
  - A subsequent operation completes correctly.
